rotary_decoder: RTL and testbench

- Conditions the raw Spartan-3E rotary-encoder pins (quadrature A/B plus centre push) into clean single-cycle events.
- Feeds the `random` position generator directly: its `rot_event` pulse is what `random` samples on. `rot_left` and `rot_press` go to game control.
- Stages: synchroniser, quadrature filter, edge detector, plus a counter-based debouncer for the push switch.

---
 rtl/rotary_decoder_pkg.sv | 40 ++++
 rtl/rotary_decoder_if.sv | 33 +++
 rtl/rotary_decoder_sync_debounce.sv | 65 ++++++
 rtl/rotary_decoder.sv | 106 ++++++++++
 tb/tb_rotary_decoder.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/rotary_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rot_pkg
// Description : Shared constants, types and helpers for the rotary-encoder
//               front end (direction encoding, quadrature phase names,
//               default debounce length, constant clog2).
// Revision    : 1.0 - initial release
// ============================================================================
package rot_pkg;

    // Direction reported on rot_left
    localparam logic ROT_CW  = 1'b0;
    localparam logic ROT_CCW = 1'b1;

    // 10 ms at 50 MHz
    localparam int c_DEBOUNCE_DEFAULT = 500000;

    // Synchronised {A,B} pin pair
    typedef enum logic [1:0] {
        PH_00 = 2'b00,
        PH_01 = 2'b01,
        PH_10 = 2'b10,
        PH_11 = 2'b11
    } quad_phase_t;

    // Number of bits needed to represent values 0 .. value-1
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rotary_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : rotary_decoder_if
// Description : Pin/event bundle between the board-level rotary encoder and
//               its decoder.
//   rot_a, rot_b   raw quadrature channels (asynchronous)
//   rot_center     raw push switch, 1 = pressed (asynchronous)
//   rot_event      one-cycle pulse per detent
//   rot_left       direction of last detent, 1 = counter-clockwise
//   rot_press      one-cycle pulse on accepted press
//   master : drives the raw pins, consumes the events
//   slave  : the decoder
// Revision    : 1.0 - initial release
// ============================================================================
interface rotary_decoder_if;
    logic rot_a;
    logic rot_b;
    logic rot_center;
    logic rot_event;
    logic rot_left;
    logic rot_press;

    modport master (
        output rot_a, rot_b, rot_center,
        input  rot_event, rot_left, rot_press
    );

    modport slave (
        input  rot_a, rot_b, rot_center,
        output rot_event, rot_left, rot_press
    );
endinterface
`default_nettype wire

// File: rtl/rotary_decoder_sync_debounce.sv
`default_nettype none
// ============================================================================
// Module      : sync_debounce
// Description : Two-flop synchroniser followed by a counter debouncer. A new
//               level is accepted after DEBOUNCE_CYCLES consecutive samples
//               that differ from the currently accepted level. o_rise pulses
//               for one cycle when the accepted level goes 0 -> 1.
//   clk     system clock
//   rst     synchronous active-high reset
//   i_raw   asynchronous input
//   o_rise  one-cycle pulse on accepted rising level
// Revision    : 1.0 - initial release
// ============================================================================
module sync_debounce
    import rot_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_DEFAULT,
    parameter int CNT_W           = clog2(DEBOUNCE_CYCLES + 1)
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_raw,
    output logic      o_rise
);

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_meta;
    logic             r_sync;
    logic             r_level;
    logic             r_level_d;
    logic             r_rise;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta    <= 1'b0;
            r_sync    <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_rise    <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_meta    <= i_raw;
            r_sync    <= r_meta;
            r_level_d <= r_level;
            r_rise    <= r_level & ~r_level_d;

            // Any sample matching the accepted level restarts the run, so
            // only an unbroken run of the opposite level is accepted.
            if (r_sync == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_level <= r_sync;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_rise = r_rise;

endmodule
`default_nettype wire

// File: rtl/rotary_decoder.sv
`default_nettype none
// ============================================================================
// Module      : rotary_decoder
// Description : Spartan-3E rotary encoder front end. Synchronises the A/B
//               quadrature pins, filters them down to one rising edge per
//               detent and reports direction; debounces the centre push.
//   clk     system clock (50 MHz)
//   reset   synchronous active-high reset
//   bus     rotary_decoder_if.slave: raw pins in, rot_event/rot_left/
//           rot_press out
// Revision    : 1.0 - initial release
// ============================================================================
module rotary_decoder
    import rot_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_DEFAULT,
    parameter int CNT_W           = clog2(DEBOUNCE_CYCLES + 1)
) (
    input  wire logic        clk,
    input  wire logic        reset,
    rotary_decoder_if.slave  bus
);

    logic        r_a_meta;
    logic        r_a_s;
    logic        r_b_meta;
    logic        r_b_s;
    logic        r_q1;
    logic        r_q2;
    logic        r_q1_d;
    logic [1:0]  r_arm_cnt;
    logic        r_armed;
    logic        r_event;
    logic        r_left;
    logic        w_press;
    logic        w_q1_rise;
    quad_phase_t w_phase;

    assign w_phase   = quad_phase_t'({r_a_s, r_b_s});
    assign w_q1_rise = r_armed & r_q1 & ~r_q1_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_meta  <= 1'b0;
            r_a_s     <= 1'b0;
            r_b_meta  <= 1'b0;
            r_b_s     <= 1'b0;
            r_q1      <= 1'b0;
            r_q2      <= 1'b0;
            r_q1_d    <= 1'b0;
            r_arm_cnt <= 2'd0;
            r_armed   <= 1'b0;
            r_event   <= 1'b0;
            r_left    <= ROT_CW;
        end else begin
            r_a_meta <= bus.rot_a;
            r_a_s    <= r_a_meta;
            r_b_meta <= bus.rot_b;
            r_b_s    <= r_b_meta;

            // q1 only moves on the 00/11 corners and q2 only on the
            // 10/01 transitions, so chatter on one channel cannot
            // produce more than one q1 edge.
            case (w_phase)
                PH_00:   r_q1 <= 1'b0;
                PH_10:   r_q2 <= ROT_CW;
                PH_01:   r_q2 <= ROT_CCW;
                PH_11:   r_q1 <= 1'b1;
                default: r_q1 <= r_q1;
            endcase

            r_q1_d <= r_q1;

            // Stay disarmed long enough for pins resting at 11 during
            // reset to propagate into q1/q1_d without firing an event.
            if (!r_armed) begin
                if (r_arm_cnt == 2'd3) begin
                    r_armed <= 1'b1;
                end else begin
                    r_arm_cnt <= r_arm_cnt + 2'd1;
                end
            end

            r_event <= w_q1_rise;
            if (w_q1_rise) begin
                r_left <= r_q2;
            end
        end
    end

    sync_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_center (
        .clk    (clk),
        .rst    (reset),
        .i_raw  (bus.rot_center),
        .o_rise (w_press)
    );

    assign bus.rot_event = r_event;
    assign bus.rot_left  = r_left;
    assign bus.rot_press = w_press;

endmodule
`default_nettype wire

// File: tb/tb_rotary_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_rotary_decoder
// Description : Self-checking bench for rotary_decoder with a short debounce
//               length. A reference model derived from the encoder rules
//               (last corner seen, last transition seen, run length of the
//               push level) predicts every output on every cycle; directed
//               scenarios add event counts and latencies.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rotary_decoder;

    localparam int DEB = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic in_a  = 1'b0;
    logic in_b  = 1'b0;
    logic in_c  = 1'b0;

    always #5 clk = ~clk;

    rotary_decoder_if u_if ();
    assign u_if.rot_a      = in_a;
    assign u_if.rot_b      = in_b;
    assign u_if.rot_center = in_c;

    rotary_decoder #(
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // corner_h[k] : value of the last 00/11 corner seen up to sample k
    // trans_h[k]  : b value of the last 10/01 transition up to sample k
    bit corner_h[$];
    bit trans_h[$];
    int press_due[$];
    int k       = -1;
    bit m_level = 1'b0;
    int diffrun = 0;
    bit exp_left = 1'b0;

    int ev_cnt  = 0;
    int ev_k    = -1;
    int pr_cnt  = 0;
    int pr_k    = -1;

    task automatic cycle();
        bit ev_exp;
        bit pr_exp;
        bit prev_c;
        bit prev_t;
        ev_exp = 1'b0;
        pr_exp = 1'b0;
        @(posedge clk);
        #1;
        if (reset) begin
            corner_h.delete();
            trans_h.delete();
            press_due.delete();
            k        = -1;
            m_level  = 1'b0;
            diffrun  = 0;
            exp_left = 1'b0;
        end else begin
            k++;
            prev_c = (k == 0) ? 1'b0 : corner_h[k-1];
            prev_t = (k == 0) ? 1'b0 : trans_h[k-1];
            corner_h.push_back((in_a == in_b) ? in_a : prev_c);
            trans_h.push_back((in_a != in_b) ? in_b : prev_t);
            // a corner rise seen at sample j is reported three edges later,
            // and only once the decoder has been out of reset for 4 edges
            if (k >= 4) begin
                ev_exp = corner_h[k-3] && !corner_h[k-4];
                if (ev_exp) exp_left = trans_h[k-3];
            end
            if (in_c != m_level) diffrun++;
            else diffrun = 0;
            if (diffrun == DEB) begin
                m_level = in_c;
                diffrun = 0;
                if (in_c) press_due.push_back(k + 3);
            end
            if (press_due.size() > 0 && press_due[0] == k) begin
                pr_exp = 1'b1;
                void'(press_due.pop_front());
            end
        end
        if (u_if.rot_event) begin ev_cnt++; ev_k = k; end
        if (u_if.rot_press) begin pr_cnt++; pr_k = k; end
        check("rot_event", 32'(u_if.rot_event), 32'(ev_exp));
        check("rot_left",  32'(u_if.rot_left),  32'(exp_left));
        check("rot_press", 32'(u_if.rot_press), 32'(pr_exp));
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    function automatic logic [1:0] gray_ab(input int g);
        case (g & 3)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    int e0;
    int p0;
    int k0;
    int g;
    logic [1:0] ab;

    initial begin
        // reset state
        reset = 1'b1;
        hold(2);
        reset = 1'b0;
        hold(8);

        // 1: B leads A -> counter-clockwise detent
        e0 = ev_cnt;
        in_b = 1'b1; hold(5);
        k0 = k;
        in_a = 1'b1; hold(6);
        check("t1_count",   32'(ev_cnt - e0), 32'd1);
        check("t1_latency", 32'(ev_k), 32'(k0 + 4));
        check("t1_left",    32'(u_if.rot_left), 32'd1);

        // 2: A leads B -> clockwise, return to 00 is silent
        in_a = 1'b0; in_b = 1'b0; hold(8);
        e0 = ev_cnt;
        in_a = 1'b1; hold(5);
        in_b = 1'b1; hold(6);
        check("t2_count", 32'(ev_cnt - e0), 32'd1);
        check("t2_left",  32'(u_if.rot_left), 32'd0);
        in_a = 1'b0; hold(3);
        in_b = 1'b0; hold(8);
        check("t2_return", 32'(ev_cnt - e0), 32'd1);

        // 3: chatter on A with B=0
        e0 = ev_cnt;
        for (int i = 0; i < 20; i++) begin
            in_a = ~in_a;
            cycle();
        end
        in_a = 1'b0; hold(6);
        check("t3_count", 32'(ev_cnt - e0), 32'd0);
        check("t3_left",  32'(u_if.rot_left), 32'd0);

        // 4: reset with pins resting at 11
        reset = 1'b1; in_a = 1'b1; in_b = 1'b1;
        hold(2);
        reset = 1'b0;
        e0 = ev_cnt;
        hold(10);
        check("t4_quiet", 32'(ev_cnt - e0), 32'd0);
        in_a = 1'b0; hold(3);
        in_b = 1'b0; hold(6);
        in_a = 1'b1; hold(3);
        in_b = 1'b1; hold(6);
        check("t4_count", 32'(ev_cnt - e0), 32'd1);

        // 5: push-switch chatter then stable press and release
        p0 = pr_cnt;
        for (int i = 0; i < 30; i++) begin
            in_c = ((i / 3) % 2) == 0;
            cycle();
        end
        check("t5_chatter", 32'(pr_cnt - p0), 32'd0);
        k0 = k;
        in_c = 1'b1; hold(12);
        check("t5_count",   32'(pr_cnt - p0), 32'd1);
        check("t5_latency", 32'(pr_k), 32'(k0 + 11));
        in_c = 1'b0; hold(14);
        check("t5_release", 32'(pr_cnt - p0), 32'd1);

        // 6: reset lands on the edge the event would fire
        in_a = 1'b0; hold(3);
        in_b = 1'b0; hold(6);
        e0 = ev_cnt;
        in_b = 1'b1; hold(3);
        in_a = 1'b1; hold(3);
        reset = 1'b1; cycle();
        reset = 1'b0; hold(8);
        check("t6_count", 32'(ev_cnt - e0), 32'd0);
        check("t6_left",  32'(u_if.rot_left), 32'd0);

        // random walk on the Gray sequence with chatter, press noise, resets
        g = 2;
        e0 = ev_cnt;
        p0 = pr_cnt;
        for (int it = 0; it < 600; it++) begin
            int r;
            int len;
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                reset = 1'b1;
                hold(int'($urandom_range(1, 2)));
                reset = 1'b0;
            end else begin
                if (r < 50) g = g + 1;
                else if (r < 90) g = g + 3;
                ab = gray_ab(g);
                in_a = ab[1];
                in_b = ab[0];
                len = int'($urandom_range(1, 6));
                for (int j = 0; j < len; j++) begin
                    if ($urandom_range(0, 11) == 0) in_c = ~in_c;
                    cycle();
                end
            end
        end
        check("rand_events_seen", 32'(ev_cnt - e0 > 0), 32'd1);
        check("rand_press_seen",  32'(pr_cnt - p0 > 0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
